// File: rtl/alu_seq_unit_pkg.sv
// Shared types for the sequential ALU: opcode encoding, controller states
// and the packed status-flag record.
package alu_pkg;

  // Opcode map, identical to the combinational ALU it replaces
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_MUL  = 4'b0010,
    ALU_DIV  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_ROL  = 4'b0110,
    ALU_ROR  = 4'b0111,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_NOR  = 4'b1011,
    ALU_NAND = 4'b1100,
    ALU_XNOR = 4'b1101,
    ALU_GT   = 4'b1110,
    ALU_EQ   = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic dbz;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle of the sequential ALU.
// Optional macro ALU_SEQ_MUL_HI_EN adds the mul_hi result field.
interface alu_seq_unit_if #(
  parameter int ALU_SIZE = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [ALU_SIZE-1:0] alu_in_a;
  logic [ALU_SIZE-1:0] alu_in_b;
  logic [3:0]          alu_sel;
  logic                out_valid;
  logic                out_ready;
  logic [ALU_SIZE-1:0] alu_out;
  logic [ALU_SIZE-1:0] alu_rem;
  logic                carry_out;
  logic                zero_flag;
  logic                neg_flag;
  logic                ovf_flag;
  logic                dbz_flag;
`ifdef ALU_SEQ_MUL_HI_EN
  logic [ALU_SIZE-1:0] mul_hi;
`endif

  // Requester side: issues operations and consumes results
  modport master (
    output in_valid, alu_in_a, alu_in_b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out, alu_rem,
           carry_out, zero_flag, neg_flag, ovf_flag, dbz_flag
`ifdef ALU_SEQ_MUL_HI_EN
           , mul_hi
`endif
  );

  // ALU side
  modport slave (
    input  in_valid, alu_in_a, alu_in_b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out, alu_rem,
           carry_out, zero_flag, neg_flag, ovf_flag, dbz_flag
`ifdef ALU_SEQ_MUL_HI_EN
           , mul_hi
`endif
  );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide.
// One iteration per cycle for ALU_SIZE cycles; hi_o/lo_o present the value
// after the current iteration so the final one can be captured with done_o.
// MUL: {hi,lo} = product.  DIV: lo = quotient, hi = remainder.
module alu_seq_muldiv #(
  parameter int ALU_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                div_i,
  input  logic [ALU_SIZE-1:0] a_i,
  input  logic [ALU_SIZE-1:0] b_i,
  output logic                done_o,
  output logic [ALU_SIZE-1:0] hi_o,
  output logic [ALU_SIZE-1:0] lo_o
);

  localparam int CNT_W = $clog2(ALU_SIZE) + 1;

  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                div_q, div_d;
  logic [ALU_SIZE-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [ALU_SIZE-1:0] hi_step, lo_step;
  logic [ALU_SIZE:0]   sum, shifted, diff;

  // One iteration of whichever algorithm is loaded
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[ALU_SIZE-1]};
    diff    = shifted - {1'b0, b_q};
    hi_step = sum[ALU_SIZE:1];
    lo_step = {sum[0], lo_q[ALU_SIZE-1:1]};
    if (div_q) begin
      if (!diff[ALU_SIZE]) begin
        hi_step = diff[ALU_SIZE-1:0];
        lo_step = {lo_q[ALU_SIZE-2:0], 1'b1};
      end else begin
        hi_step = shifted[ALU_SIZE-1:0];
        lo_step = {lo_q[ALU_SIZE-2:0], 1'b0};
      end
    end
  end

  // Load on start, iterate while busy, stop after the last iteration
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    if (start_i) begin
      count_d = CNT_W'(ALU_SIZE);
      busy_d  = 1'b1;
      div_d   = div_i;
      hi_d    = '0;
      lo_d    = a_i;
      b_d     = b_i;
    end else if (busy_q) begin
      hi_d    = hi_step;
      lo_d    = lo_step;
      count_d = count_q - CNT_W'(1);
      if (count_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
    end
  end

  assign done_o = busy_q && (count_q == CNT_W'(1));
  assign hi_o   = hi_step;
  assign lo_o   = lo_step;

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes, one transaction in flight.
// Single-cycle ops complete in one cycle; MUL and DIV (B != 0) iterate in
// alu_seq_muldiv. Optional macro ALU_SEQ_MUL_HI_EN exposes the upper
// product half on mul_hi.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int ALU_SIZE = 16,
  parameter int SHAMT_W  = $clog2(ALU_SIZE)
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]          state_q, state_d;
  alu_op_e             op_q, op_d, sel;
  logic [ALU_SIZE-1:0] out_q, out_d, rem_q, rem_d;
  alu_flags_t          flags_q, flags_d;
`ifdef ALU_SEQ_MUL_HI_EN
  logic [ALU_SIZE-1:0] hi_q, hi_d;
`endif

  logic                md_start, md_done;
  logic [ALU_SIZE-1:0] md_hi, md_lo;

  logic [ALU_SIZE-1:0] a, b, sc_out, sc_rem;
  logic                sc_carry, sc_ovf, sc_dbz, needs_iter;
  logic [ALU_SIZE:0]   wide;
  logic [SHAMT_W-1:0]  shamt;
  logic [SHAMT_W:0]    shamt_inv;

  assign a   = bus.alu_in_a;
  assign b   = bus.alu_in_b;
  assign sel = alu_op_e'(bus.alu_sel);

  // Results of every op that finishes in the accepting cycle
  always_comb begin
    sc_out    = '0;
    sc_rem    = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    sc_dbz    = 1'b0;
    wide      = '0;
    shamt     = b[SHAMT_W-1:0];
    shamt_inv = (SHAMT_W+1)'(ALU_SIZE) - {1'b0, shamt};
    case (sel)
      ALU_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        sc_out   = wide[ALU_SIZE-1:0];
        sc_carry = wide[ALU_SIZE];
        sc_ovf   = (a[ALU_SIZE-1] == b[ALU_SIZE-1]) && (sc_out[ALU_SIZE-1] != a[ALU_SIZE-1]);
      end
      ALU_SUB: begin
        wide     = {1'b0, a} - {1'b0, b};
        sc_out   = wide[ALU_SIZE-1:0];
        sc_carry = wide[ALU_SIZE];
        sc_ovf   = (a[ALU_SIZE-1] != b[ALU_SIZE-1]) && (sc_out[ALU_SIZE-1] != a[ALU_SIZE-1]);
      end
      ALU_DIV: begin
        sc_out = '1;
        sc_rem = a;
        sc_dbz = 1'b1;
      end
      ALU_SLL:  sc_out = a << shamt;
      ALU_SRL:  sc_out = a >> shamt;
      ALU_ROL:  sc_out = (a << shamt) | (a >> shamt_inv);
      ALU_ROR:  sc_out = (a >> shamt) | (a << shamt_inv);
      ALU_AND:  sc_out = a & b;
      ALU_OR:   sc_out = a | b;
      ALU_XOR:  sc_out = a ^ b;
      ALU_NOR:  sc_out = ~(a | b);
      ALU_NAND: sc_out = ~(a & b);
      ALU_XNOR: sc_out = ~(a ^ b);
      ALU_GT:   sc_out = {{(ALU_SIZE-1){1'b0}}, (a > b)};
      ALU_EQ:   sc_out = {{(ALU_SIZE-1){1'b0}}, (a == b)};
      default:  sc_out = '0;
    endcase
  end

  assign needs_iter = (sel == ALU_MUL) || ((sel == ALU_DIV) && (b != '0));

  // Controller: accept in IDLE, wait for the iterative unit, hold in DONE
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    out_d    = out_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    md_start = 1'b0;
`ifdef ALU_SEQ_MUL_HI_EN
    hi_d     = hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d = sel;
          if (needs_iter) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            out_d         = sc_out;
            rem_d         = sc_rem;
            flags_d.carry = sc_carry;
            flags_d.zero  = (sc_out == '0);
            flags_d.neg   = sc_out[ALU_SIZE-1];
            flags_d.ovf   = sc_ovf;
            flags_d.dbz   = sc_dbz;
`ifdef ALU_SEQ_MUL_HI_EN
            hi_d          = '0;
`endif
            state_d       = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          out_d         = md_lo;
          rem_d         = (op_q == ALU_DIV) ? md_hi : '0;
          flags_d.carry = 1'b0;
          flags_d.zero  = (md_lo == '0);
          flags_d.neg   = md_lo[ALU_SIZE-1];
          flags_d.ovf   = (op_q == ALU_MUL) && (md_hi != '0);
          flags_d.dbz   = 1'b0;
`ifdef ALU_SEQ_MUL_HI_EN
          hi_d          = (op_q == ALU_MUL) ? md_hi : '0;
`endif
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_ADD;
      out_q   <= '0;
      rem_q   <= '0;
      flags_q <= '0;
`ifdef ALU_SEQ_MUL_HI_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      flags_q <= flags_d;
`ifdef ALU_SEQ_MUL_HI_EN
      hi_q    <= hi_d;
`endif
    end
  end

  alu_seq_muldiv #(.ALU_SIZE(ALU_SIZE)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .div_i   (sel == ALU_DIV),
    .a_i     (a),
    .b_i     (b),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.alu_out   = out_q;
  assign bus.alu_rem   = rem_q;
  assign bus.carry_out = flags_q.carry;
  assign bus.zero_flag = flags_q.zero;
  assign bus.neg_flag  = flags_q.neg;
  assign bus.ovf_flag  = flags_q.ovf;
  assign bus.dbz_flag  = flags_q.dbz;
`ifdef ALU_SEQ_MUL_HI_EN
  assign bus.mul_hi    = hi_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit at ALU_SIZE = 16.
// Honours ALU_SEQ_MUL_HI_EN when it is defined for the build.
module tb_alu_seq_unit;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  logic clk;
  logic rst_n;
  int   cmpCount;
  int   failCount;

  alu_seq_unit_if #(.ALU_SIZE(16)) bus ();

  alu_seq_unit #(.ALU_SIZE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one op, wait for out_valid; lat = cycles from accept edge, -1 on timeout
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, output int lat);
    int n;
    bus.alu_sel  = op;
    bus.alu_in_a = a;
    bus.alu_in_b = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = bus.out_valid ? n + 1 : -1;
  endtask

  // Consume the pending result with a one-cycle out_ready pulse
  task automatic releaseResult();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmpCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
    cmpCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    cmpCount++; if (bus.alu_out !== 16'h0) begin failCount++; $display("[TB] FAIL reset_alu_out got %h want 0000", bus.alu_out); end
    cmpCount++; if (bus.alu_rem !== 16'h0) begin failCount++; $display("[TB] FAIL reset_alu_rem got %h want 0000", bus.alu_rem); end
    cmpCount++;
    if ({bus.carry_out, bus.zero_flag, bus.neg_flag, bus.ovf_flag, bus.dbz_flag} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_flags got %b want 00000",
               {bus.carry_out, bus.zero_flag, bus.neg_flag, bus.ovf_flag, bus.dbz_flag});
    end
  endtask

  task automatic test_add_sub();
    int lat;
    applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, lat);
    cmpCount++; if (lat !== 1) begin failCount++; $display("[TB] FAIL add_latency got %0d want 1", lat); end
    cmpCount++; if (bus.alu_out !== 16'h0000) begin failCount++; $display("[TB] FAIL add_out got %h want 0000", bus.alu_out); end
    cmpCount++; if (bus.carry_out !== 1'b1) begin failCount++; $display("[TB] FAIL add_carry got %b want 1", bus.carry_out); end
    cmpCount++; if (bus.zero_flag !== 1'b1) begin failCount++; $display("[TB] FAIL add_zero got %b want 1", bus.zero_flag); end
    cmpCount++; if (bus.ovf_flag !== 1'b0) begin failCount++; $display("[TB] FAIL add_ovf got %b want 0", bus.ovf_flag); end
    releaseResult();
    applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, lat);
    cmpCount++; if (bus.alu_out !== 16'h8000) begin failCount++; $display("[TB] FAIL add_ovf_out got %h want 8000", bus.alu_out); end
    cmpCount++; if (bus.ovf_flag !== 1'b1) begin failCount++; $display("[TB] FAIL add_ovf_flag got %b want 1", bus.ovf_flag); end
    releaseResult();
    applyStimulus(OP_SUB, 16'h0003, 16'h0005, lat);
    cmpCount++; if (bus.alu_out !== 16'hFFFE) begin failCount++; $display("[TB] FAIL sub_out got %h want fffe", bus.alu_out); end
    cmpCount++; if (bus.carry_out !== 1'b1) begin failCount++; $display("[TB] FAIL sub_borrow got %b want 1", bus.carry_out); end
    cmpCount++; if (bus.neg_flag !== 1'b1) begin failCount++; $display("[TB] FAIL sub_neg got %b want 1", bus.neg_flag); end
    cmpCount++; if (bus.zero_flag !== 1'b0) begin failCount++; $display("[TB] FAIL sub_zero got %b want 0", bus.zero_flag); end
    releaseResult();
  endtask

  task automatic test_mul();
    int lat;
    applyStimulus(OP_MUL, 16'h0100, 16'h0100, lat);
    cmpCount++; if (lat !== 17) begin failCount++; $display("[TB] FAIL mul_latency got %0d want 17", lat); end
    cmpCount++; if (bus.alu_out !== 16'h0000) begin failCount++; $display("[TB] FAIL mul_big_out got %h want 0000", bus.alu_out); end
    cmpCount++; if (bus.ovf_flag !== 1'b1) begin failCount++; $display("[TB] FAIL mul_big_ovf got %b want 1", bus.ovf_flag); end
    cmpCount++; if (bus.zero_flag !== 1'b1) begin failCount++; $display("[TB] FAIL mul_big_zero got %b want 1", bus.zero_flag); end
`ifdef ALU_SEQ_MUL_HI_EN
    cmpCount++; if (bus.mul_hi !== 16'h0001) begin failCount++; $display("[TB] FAIL mul_hi got %h want 0001", bus.mul_hi); end
`endif
    releaseResult();
    applyStimulus(OP_MUL, 16'd7, 16'd6, lat);
    cmpCount++; if (lat !== 17) begin failCount++; $display("[TB] FAIL mul_small_latency got %0d want 17", lat); end
    cmpCount++; if (bus.alu_out !== 16'h002A) begin failCount++; $display("[TB] FAIL mul_small_out got %h want 002a", bus.alu_out); end
    cmpCount++; if (bus.ovf_flag !== 1'b0) begin failCount++; $display("[TB] FAIL mul_small_ovf got %b want 0", bus.ovf_flag); end
    cmpCount++; if (bus.alu_rem !== 16'h0000) begin failCount++; $display("[TB] FAIL mul_small_rem got %h want 0000", bus.alu_rem); end
    releaseResult();
    applyStimulus(OP_MUL, 16'h1234, 16'h0011, lat);
    cmpCount++; if (bus.alu_out !== 16'h3574) begin failCount++; $display("[TB] FAIL mul_mid_out got %h want 3574", bus.alu_out); end
    cmpCount++; if (bus.ovf_flag !== 1'b1) begin failCount++; $display("[TB] FAIL mul_mid_ovf got %b want 1", bus.ovf_flag); end
    releaseResult();
  endtask

  task automatic test_div();
    int lat;
    applyStimulus(OP_DIV, 16'd100, 16'd7, lat);
    cmpCount++; if (lat !== 17) begin failCount++; $display("[TB] FAIL div_latency got %0d want 17", lat); end
    cmpCount++; if (bus.alu_out !== 16'd14) begin failCount++; $display("[TB] FAIL div_quot got %0d want 14", bus.alu_out); end
    cmpCount++; if (bus.alu_rem !== 16'd2) begin failCount++; $display("[TB] FAIL div_rem got %0d want 2", bus.alu_rem); end
    cmpCount++; if (bus.dbz_flag !== 1'b0) begin failCount++; $display("[TB] FAIL div_dbz got %b want 0", bus.dbz_flag); end
    releaseResult();
    applyStimulus(OP_DIV, 16'hFFFF, 16'h0010, lat);
    cmpCount++; if (bus.alu_out !== 16'h0FFF) begin failCount++; $display("[TB] FAIL div_big_quot got %h want 0fff", bus.alu_out); end
    cmpCount++; if (bus.alu_rem !== 16'h000F) begin failCount++; $display("[TB] FAIL div_big_rem got %h want 000f", bus.alu_rem); end
    releaseResult();
    applyStimulus(OP_DIV, 16'h1234, 16'h0000, lat);
    cmpCount++; if (lat !== 1) begin failCount++; $display("[TB] FAIL dbz_latency got %0d want 1", lat); end
    cmpCount++; if (bus.alu_out !== 16'hFFFF) begin failCount++; $display("[TB] FAIL dbz_out got %h want ffff", bus.alu_out); end
    cmpCount++; if (bus.alu_rem !== 16'h1234) begin failCount++; $display("[TB] FAIL dbz_rem got %h want 1234", bus.alu_rem); end
    cmpCount++; if (bus.dbz_flag !== 1'b1) begin failCount++; $display("[TB] FAIL dbz_flag got %b want 1", bus.dbz_flag); end
    releaseResult();
  endtask

  task automatic test_shift_logic();
    int lat;
    logic [3:0]  ops [7] = '{OP_ROL, OP_SRL, OP_SLL, OP_ROR, OP_NAND, OP_GT, OP_EQ};
    logic [15:0] as  [7] = '{16'h8001, 16'h8000, 16'hA5A5, 16'h0001, 16'hFFFF, 16'h0005, 16'h0007};
    logic [15:0] bs  [7] = '{16'h0004, 16'h000F, 16'h0010, 16'h0001, 16'h0F0F, 16'h0003, 16'h0007};
    logic [15:0] exp [7] = '{16'h0018, 16'h0001, 16'hA5A5, 16'h8000, 16'hF0F0, 16'h0001, 16'h0001};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(ops[i], as[i], bs[i], lat);
      cmpCount++;
      if (bus.alu_out !== exp[i]) begin
        failCount++;
        $display("[TB] FAIL shift_logic[%0d] op=%b got %h want %h", i, ops[i], bus.alu_out, exp[i]);
      end
      releaseResult();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    applyStimulus(OP_ADD, 16'd1, 16'd2, lat);
    bus.alu_sel  = OP_SUB;
    bus.alu_in_a = 16'd9;
    bus.alu_in_b = 16'd9;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cmpCount++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.alu_out !== 16'd3 || bus.zero_flag !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL hold[%0d] got valid=%b ready=%b out=%h zero=%b want 1 0 0003 0",
                 i, bus.out_valid, bus.in_ready, bus.alu_out, bus.zero_flag);
      end
    end
    bus.in_valid = 1'b0;
    releaseResult();
    cmpCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL post_handshake_ready got %b want 1", bus.in_ready); end
    cmpCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL post_handshake_valid got %b want 0", bus.out_valid); end
    applyStimulus(OP_ADD, 16'd4, 16'd4, lat);
    cmpCount++; if (lat !== 1) begin failCount++; $display("[TB] FAIL next_op_latency got %0d want 1", lat); end
    cmpCount++; if (bus.alu_out !== 16'd8) begin failCount++; $display("[TB] FAIL next_op_out got %h want 0008", bus.alu_out); end
    releaseResult();
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int seen;
    bus.alu_sel  = OP_DIV;
    bus.alu_in_a = 16'd100;
    bus.alu_in_b = 16'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmpCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL abort_valid got %b want 0", bus.out_valid); end
    cmpCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL abort_ready got %b want 1", bus.in_ready); end
    cmpCount++;
    if (bus.alu_out !== 16'h0 || bus.alu_rem !== 16'h0 ||
        {bus.carry_out, bus.zero_flag, bus.neg_flag, bus.ovf_flag, bus.dbz_flag} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL abort_outputs got out=%h rem=%h flags=%b want 0000 0000 00000", bus.alu_out, bus.alu_rem,
               {bus.carry_out, bus.zero_flag, bus.neg_flag, bus.ovf_flag, bus.dbz_flag});
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    cmpCount++; if (seen !== 0) begin failCount++; $display("[TB] FAIL abort_no_result got %0d valid cycles want 0", seen); end
    applyStimulus(OP_ADD, 16'd2, 16'd3, lat);
    cmpCount++; if (bus.alu_out !== 16'd5) begin failCount++; $display("[TB] FAIL after_abort_add got %h want 0005", bus.alu_out); end
    releaseResult();
  endtask

  // Run every scenario in order, then report
  initial begin
    cmpCount      = 0;
    failCount     = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_in_a  = '0;
    bus.alu_in_b  = '0;
    bus.alu_sel   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_shift_logic();
    test_backpressure();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Sequential, parametrised successor to the combinational ALU for the MIPS processor datapath.
- Accepts one operation per transaction over a valid/ready handshake.
- Single-cycle ops: registered result, 1-cycle latency.
- Multiply/divide: iterative, multi-cycle.
- Generalises shifts/rotates to a variable amount taken from operand B.
- Adds a remainder output and status flags (carry, zero, negative, overflow, divide-by-zero).

Parameters:
- ALU_SIZE, 16, operand/result bit width (>=4, power of 2).
- SHAMT_W, $clog2(ALU_SIZE), width of the shift/rotate amount field taken from alu_in_b[SHAMT_W-1:0].

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- alu_in_a  input  ALU_SIZE  operand A.
- alu_in_b  input  ALU_SIZE  operand B / shift amount.
- alu_sel  input  4  opcode (alu_op_e; same 16-op encoding as current ALU).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- alu_out  output  ALU_SIZE  result.
- alu_rem  output  ALU_SIZE  remainder for DIV, else 0.
- carry_out  output  1  ADD carry-out / SUB borrow, else 0.
- zero_flag  output  1  alu_out == 0.
- neg_flag  output  1  alu_out[ALU_SIZE-1].
- ovf_flag  output  1  signed overflow for ADD/SUB; upper product half nonzero for MUL; else 0.
- dbz_flag  output  1  DIV with alu_in_b == 0.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; counter cleared.
  - All outputs 0 except in_ready = 1.
  - Reset mid-operation aborts it; no result is produced.
- States:
  - IDLE: in_ready = 1. On in_valid, capture operands and opcode.
    - MUL, or DIV with B != 0: go to BUSY, load count = ALU_SIZE.
    - All other ops (including DIV with B == 0): compute into the result registers and go to DONE.
  - BUSY: one iteration per cycle, count decrements. When count reaches 1, load the result registers and go to DONE.
    - MUL: shift-add, unsigned.
    - DIV: restoring, unsigned.
  - DONE: out_valid = 1. Outputs and flags are held stable until out_ready is high, then return to IDLE. in_ready = 0 throughout.
- Latency, from accept edge to out_valid high:
  - 1 cycle for single-cycle ops.
  - ALU_SIZE+1 cycles for MUL/DIV.
- Throughput: one transaction in flight. The earliest next accept is the cycle after the out handshake.
- Arithmetic:
  - ADD/SUB are computed at ALU_SIZE+1 bits; carry_out is bit ALU_SIZE. For SUB, carry_out = 1 means borrow (A < B unsigned).
  - MUL result = low ALU_SIZE bits of the product.
  - DIV: quotient in alu_out, remainder in alu_rem.
  - DIV by zero: alu_out = all ones, alu_rem = A, dbz_flag = 1, 1-cycle latency.
- Shifts: SLL/SRL/ROL/ROR by amount B[SHAMT_W-1:0] (range 0..ALU_SIZE-1). Amount 0 leaves A unchanged.
- Logic ops: AND/OR/XOR/NOR/NAND/XNOR, as in the current ALU.
- Compares: GT and EQ are unsigned; result is 1 or 0 zero-extended.
- Inputs while not in IDLE are ignored (in_ready = 0).
- out_valid never drops without out_ready.

Optional Feature:
- Macro: ALU_SEQ_MUL_HI_EN.
- Defined: adds port mul_hi (output, ALU_SIZE) holding the upper product half for MUL (0 for other ops), registered with alu_out and held in DONE.
- Undefined: port absent. ovf_flag still reports a nonzero upper half.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (ADD = 4'b0000 … EQ = 4'b1111).
  - alu_state_e (IDLE, BUSY, DONE).
  - alu_flags_t packed struct {carry, zero, neg, ovf, dbz}.
- Sub-module alu_seq_muldiv holds the iterative shift-add/restoring-divide datapath and its counter. It exposes start, op, operands, done, hi/lo results.

Test Plan:
- ADD 0xFFFF+0x0001 (ALU_SIZE=16) → alu_out 0x0000, carry_out 1, zero_flag 1; out_valid 1 cycle after accept.
- MUL 0x0100*0x0100 → alu_out 0x0000, ovf_flag 1 (mul_hi 0x0001 with macro); out_valid 17 cycles after accept. MUL 7*6 → 0x002A, ovf 0.
- DIV 100/7 → alu_out 14, alu_rem 2, latency 17. DIV 0x1234/0 → alu_out 0xFFFF, alu_rem 0x1234, dbz_flag 1, latency 1.
- ROL 0x8001 by B=4 → 0x0018. SRL 0x8000 by B=15 → 0x0001. SUB 3−5 → 0xFFFE, carry_out 1, neg_flag 1.
- Backpressure: out_ready low for 5 cycles in DONE → outputs stable, in_ready 0, new in_valid ignored. After the out handshake, in_ready 1 next cycle.
- rst_n low during cycle 8 of a DIV → next cycle out_valid 0, in_ready 1, all outputs 0; a following ADD 2+3 returns 5.
